// File: rtl/nn_img_pkg.sv
// Shared constants and state encoding for the image buffer and its reader/writer.
package nn_img_pkg;

  localparam int unsigned DATA_WIDTH       = 8;
  localparam int unsigned ADDR_WIDTH       = 10;
  localparam int unsigned TOTAL_DATA_WIDTH = DATA_WIDTH * 6;

  localparam int unsigned FIFO_DEPTH     = 4;
  localparam int unsigned FIFO_CNT_WIDTH = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StDrain,
    StFin
  } rd_state_e;

endpackage

// File: rtl/nn_sync_fifo.sv
// Small synchronous FIFO with occupancy count; push when full / pop when empty are ignored.
module nn_sync_fifo import nn_img_pkg::*; #(
  parameter int unsigned WIDTH = TOTAL_DATA_WIDTH + 1
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_push,
  input  logic [WIDTH-1:0]          i_wdata,
  input  logic                      i_pop,
  output logic [WIDTH-1:0]          o_rdata,
  output logic [FIFO_CNT_WIDTH-1:0] o_count,
  output logic                      o_empty,
  output logic                      o_full
);

  localparam int unsigned PtrWidth = $clog2(FIFO_DEPTH);

  logic [WIDTH-1:0]          r_mem [FIFO_DEPTH];
  logic [PtrWidth-1:0]       r_wr_ptr;
  logic [PtrWidth-1:0]       r_rd_ptr;
  logic [FIFO_CNT_WIDTH-1:0] r_count;
  logic                      w_push;
  logic                      w_pop;

  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == FIFO_CNT_WIDTH'(FIFO_DEPTH));
  assign o_count = r_count;
  assign o_rdata = r_mem[r_rd_ptr];
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;

  // Storage carries no reset; the head is only consumed while the count is non-zero.
  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_wdata;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PtrWidth'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PtrWidth'(1);
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + FIFO_CNT_WIDTH'(1);
        2'b01:   r_count <= r_count - FIFO_CNT_WIDTH'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/nn_img_rd_ctrl.sv
// Image-buffer read controller: sweeps an address range, absorbs the one-cycle read
// latency and streams rows out through a credit-protected FIFO with a last flag.
module nn_img_rd_ctrl #(
  parameter int unsigned DATA_WIDTH       = nn_img_pkg::DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH       = nn_img_pkg::ADDR_WIDTH,
  parameter int unsigned TOTAL_DATA_WIDTH = DATA_WIDTH * 6,
  parameter int unsigned LEN_WIDTH        = ADDR_WIDTH + 1
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic                        i_start,
  input  logic [ADDR_WIDTH-1:0]       i_base_addr,
  input  logic [LEN_WIDTH-1:0]        i_len,
  input  logic                        i_bf_wr_busy,
  output logic                        o_bf_rd_en,
  output logic [ADDR_WIDTH-1:0]       o_bf_rd_addr,
  input  logic [TOTAL_DATA_WIDTH-1:0] i_bf_rd_data,
  output logic [TOTAL_DATA_WIDTH-1:0] o_data,
  output logic                        o_valid,
  input  logic                        i_ready,
  output logic                        o_last,
  output logic                        o_busy,
  output logic                        o_done
);

  import nn_img_pkg::*;

  rd_state_e                 r_state;
  rd_state_e                 w_state_nxt;
  logic [ADDR_WIDTH-1:0]     r_addr;
  logic [LEN_WIDTH-1:0]      r_remain;
  logic                      r_inflight;
  logic                      r_inflight_last;
  logic                      r_done;
  logic                      w_done_nxt;
  logic                      w_rd_en;
  logic                      w_last_rd;
  logic                      w_pop;
  logic [TOTAL_DATA_WIDTH:0] w_fifo_rdata;
  logic [FIFO_CNT_WIDTH-1:0] w_fifo_count;
  logic                      w_fifo_empty;
  logic                      w_fifo_full;

  // An in-flight read already owns a FIFO slot; a same-cycle pop is deliberately not credited.
  assign w_rd_en = (r_state == StIssue) && !i_bf_wr_busy &&
                   ((w_fifo_count + FIFO_CNT_WIDTH'(r_inflight)) < FIFO_CNT_WIDTH'(FIFO_DEPTH));
  assign w_last_rd  = (r_remain == LEN_WIDTH'(1));
  assign w_done_nxt = (r_state == StFin) && !r_done;
  assign w_pop      = o_valid && i_ready;

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      StIdle:  if (i_start) w_state_nxt = (i_len == '0) ? StFin : StIssue;
      StIssue: if (w_rd_en && w_last_rd) w_state_nxt = StDrain;
      StDrain: if (w_fifo_empty && !r_inflight) w_state_nxt = StFin;
      StFin:   if (r_done) w_state_nxt = StIdle;
      default: w_state_nxt = StIdle;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state         <= StIdle;
      r_addr          <= '0;
      r_remain        <= '0;
      r_inflight      <= 1'b0;
      r_inflight_last <= 1'b0;
      r_done          <= 1'b0;
    end else begin
      r_state         <= w_state_nxt;
      r_inflight      <= w_rd_en;
      r_inflight_last <= w_rd_en && w_last_rd;
      r_done          <= w_done_nxt;
      if ((r_state == StIdle) && i_start) begin
        r_addr   <= i_base_addr;
        r_remain <= i_len;
      end else if (w_rd_en) begin
        r_addr   <= r_addr + ADDR_WIDTH'(1);
        r_remain <= r_remain - LEN_WIDTH'(1);
      end
    end
  end

  nn_sync_fifo #(
    .WIDTH (TOTAL_DATA_WIDTH + 1)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_push  (r_inflight),
    .i_wdata ({r_inflight_last, i_bf_rd_data}),
    .i_pop   (w_pop),
    .o_rdata (w_fifo_rdata),
    .o_count (w_fifo_count),
    .o_empty (w_fifo_empty),
    .o_full  (w_fifo_full)
  );

  assign o_bf_rd_en   = w_rd_en;
  assign o_bf_rd_addr = r_addr;
  assign o_valid      = !w_fifo_empty;
  assign o_data       = o_valid ? w_fifo_rdata[TOTAL_DATA_WIDTH-1:0] : '0;
  assign o_last       = o_valid && w_fifo_rdata[TOTAL_DATA_WIDTH];
  assign o_busy       = (r_state != StIdle);
  assign o_done       = r_done;

endmodule

// File: tb/tb_nn_img_rd_ctrl.sv
// Directed + randomized bench for nn_img_rd_ctrl with a behavioural buffer and beat-queue model.
module tb_nn_img_rd_ctrl;

  localparam int DW = 48;
  localparam int AW = 10;
  localparam int LW = 11;

  logic          i_clk = 1'b0;
  logic          i_rst;
  logic          i_start;
  logic [AW-1:0] i_base_addr;
  logic [LW-1:0] i_len;
  logic          i_bf_wr_busy;
  logic          o_bf_rd_en;
  logic [AW-1:0] o_bf_rd_addr;
  logic [DW-1:0] i_bf_rd_data;
  logic [DW-1:0] o_data;
  logic          o_valid;
  logic          i_ready;
  logic          o_last;
  logic          o_busy;
  logic          o_done;

  always #5 i_clk = ~i_clk;

  nn_img_rd_ctrl dut (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_start      (i_start),
    .i_base_addr  (i_base_addr),
    .i_len        (i_len),
    .i_bf_wr_busy (i_bf_wr_busy),
    .o_bf_rd_en   (o_bf_rd_en),
    .o_bf_rd_addr (o_bf_rd_addr),
    .i_bf_rd_data (i_bf_rd_data),
    .o_data       (o_data),
    .o_valid      (o_valid),
    .i_ready      (i_ready),
    .o_last       (o_last),
    .o_busy       (o_busy),
    .o_done       (o_done)
  );

  // Buffer model: registered read, reads ignored while a write is in progress.
  logic [DW-1:0] mem [1024];
  always @(posedge i_clk) begin
    if (o_bf_rd_en && !i_bf_wr_busy) i_bf_rd_data <= mem[o_bf_rd_addr];
  end

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int c0 = 0;
  int rd_cnt = 0, rd_in_busy = 0, busy_cyc = 0, done_cnt = 0, valid_cyc = 0, beats_seen = 0;
  int first_valid = -1, last_valid = -1;
  logic          prev_stall = 1'b0;
  logic [DW-1:0] prev_data;
  logic          prev_last;
  logic [AW-1:0] addr_q[$];
  logic [DW:0]   beat_q[$];

  always @(posedge i_clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Stream/issue monitor against the expected address and beat queues.
  always @(negedge i_clk) begin
    if (i_rst) begin
      prev_stall = 1'b0;
    end else begin
      if (o_bf_rd_en) begin
        rd_cnt++;
        if (i_bf_wr_busy) rd_in_busy++;
        chk("rd_expected", 64'(addr_q.size() > 0), 64'(1));
        if (addr_q.size() > 0) chk("rd_addr", 64'(o_bf_rd_addr), 64'(addr_q.pop_front()));
      end
      if (o_busy) busy_cyc++;
      if (o_done) done_cnt++;
      if (o_valid) begin
        valid_cyc++;
        if (first_valid < 0) first_valid = cyc - c0;
        last_valid = cyc - c0;
      end
      if (prev_stall && o_valid) begin
        chk("stall_data", 64'(o_data), 64'(prev_data));
        chk("stall_last", 64'(o_last), 64'(prev_last));
      end
      if (o_valid && i_ready) begin
        logic [DW:0] e;
        beats_seen++;
        chk("beat_expected", 64'(beat_q.size() > 0), 64'(1));
        if (beat_q.size() > 0) begin
          e = beat_q.pop_front();
          chk("beat_data", 64'(o_data), 64'(e[DW-1:0]));
          chk("beat_last", 64'(o_last), 64'(e[DW]));
        end
      end
      prev_stall = o_valid && !i_ready;
      prev_data  = o_data;
      prev_last  = o_last;
    end
  end

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_rd_en"}, 64'(o_bf_rd_en), 64'(0));
    chk({tag, "_rd_addr"}, 64'(o_bf_rd_addr), 64'(0));
    chk({tag, "_valid"}, 64'(o_valid), 64'(0));
    chk({tag, "_last"}, 64'(o_last), 64'(0));
    chk({tag, "_busy"}, 64'(o_busy), 64'(0));
    chk({tag, "_done"}, 64'(o_done), 64'(0));
    chk({tag, "_data"}, 64'(o_data), 64'(0));
  endtask

  task automatic expect_xfer(input int base, input int len);
    for (int i = 0; i < len; i++) begin
      logic [AW-1:0] a;
      a = AW'(base + i);
      addr_q.push_back(a);
      beat_q.push_back({i == len - 1, mem[a]});
    end
  endtask

  // mode 0: ready held high, 1: random ready, 2: ready low until cycle 16.
  task automatic run_xfer(input int base, input int len, input int mode,
                          input int blo, input int bhi, input int restart_k);
    int k;
    int done0;
    int rd0;
    done0 = done_cnt;
    expect_xfer(base, len);
    @(posedge i_clk); #1;
    i_start = 1'b1;
    i_base_addr = AW'(base);
    i_len = LW'(len);
    i_ready = (mode != 2);
    i_bf_wr_busy = 1'b0;
    c0 = cyc;
    first_valid = -1;
    last_valid = -1;
    busy_cyc = 0;
    valid_cyc = 0;
    rd_in_busy = 0;
    rd0 = rd_cnt;
    k = 0;
    while (!((done_cnt > done0) && !o_busy) && k < 300) begin
      @(posedge i_clk); #1;
      k++;
      i_start = 1'b0;
      if (k == restart_k) begin
        i_start = 1'b1;
        i_base_addr = AW'(base + 5);
        i_len = LW'(3);
      end
      i_bf_wr_busy = (k >= blo) && (k <= bhi);
      case (mode)
        0:       i_ready = 1'b1;
        1:       i_ready = 1'($urandom_range(0, 1));
        default: i_ready = (k >= 16);
      endcase
      if (mode == 2 && k == 15) begin
        chk("t3_reads_capped", 64'(rd_cnt - rd0), 64'(4));
        chk("t3_rd_en_low", 64'(o_bf_rd_en), 64'(0));
        chk("t3_valid_held", 64'(o_valid), 64'(1));
      end
    end
    i_start = 1'b0;
    i_bf_wr_busy = 1'b0;
    chk("xfer_in_time", 64'(k < 300), 64'(1));
    chk("addr_q_drained", 64'(addr_q.size()), 64'(0));
    chk("beat_q_drained", 64'(beat_q.size()), 64'(0));
    chk("done_once", 64'(done_cnt - done0), 64'(1));
    chk("busy_after", 64'(o_busy), 64'(0));
    chk("valid_after", 64'(o_valid), 64'(0));
    chk("no_rd_while_busy", 64'(rd_in_busy), 64'(0));
  endtask

  initial begin
    int b;
    int b0;
    int done0;
    int rd0;
    int k;
    i_rst = 1'b1;
    i_start = 1'b0;
    i_base_addr = '0;
    i_len = '0;
    i_bf_wr_busy = 1'b0;
    i_ready = 1'b0;
    for (int i = 0; i < 1024; i++) mem[i] = DW'({$urandom(), $urandom()});
    for (int i = 0; i < 4; i++) mem[i] = DW'(8'h0A + i);
    #2;
    check_idle_outputs("reset");
    repeat (3) @(posedge i_clk);
    @(negedge i_clk) i_rst = 1'b0;

    // 1: basic len=4 from row 0
    run_xfer(0, 4, 0, -1, -1, -1);
    chk("t1_first_valid_cyc", 64'(first_valid), 64'(3));
    chk("t1_last_valid_cyc", 64'(last_valid), 64'(6));
    chk("t1_valid_cycles", 64'(valid_cyc), 64'(4));

    // 2: address wrap
    run_xfer(1022, 4, 0, -1, -1, -1);

    // 3: consumer stalled, credit limit
    run_xfer($urandom_range(0, 1023), 8, 2, -1, -1, -1);

    // 4: write busy during cycles 3..5
    run_xfer($urandom_range(0, 1023), 6, 0, 3, 5, -1);

    // 5: zero length, restart attempt ignored
    rd0 = rd_cnt;
    run_xfer(100, 0, 0, -1, -1, 1);
    chk("t5_no_reads", 64'(rd_cnt - rd0), 64'(0));
    chk("t5_no_valid", 64'(valid_cyc), 64'(0));
    chk("t5_busy_cycles", 64'(busy_cyc), 64'(2));
    repeat (3) @(posedge i_clk);
    #1 chk("t5_still_idle", 64'(o_busy), 64'(0));

    // 6: reset mid-transfer
    b = $urandom_range(0, 1023);
    done0 = done_cnt;
    b0 = beats_seen;
    expect_xfer(b, 8);
    @(posedge i_clk); #1;
    i_start = 1'b1;
    i_base_addr = AW'(b);
    i_len = LW'(8);
    i_ready = 1'b1;
    k = 0;
    while ((beats_seen - b0) < 2 && k < 60) begin
      @(posedge i_clk); #1;
      k++;
      i_start = 1'b0;
    end
    i_start = 1'b0;
    chk("t6_two_beats", 64'(beats_seen - b0), 64'(2));
    chk("t6_busy_before", 64'(o_busy), 64'(1));
    #2 i_rst = 1'b1;
    #1 check_idle_outputs("t6_async");
    addr_q.delete();
    beat_q.delete();
    repeat (3) @(posedge i_clk);
    @(negedge i_clk) i_rst = 1'b0;
    chk("t6_no_done", 64'(done_cnt - done0), 64'(0));
    run_xfer($urandom_range(0, 1023), 5, 0, -1, -1, -1);

    // random transfers with random ready and write-busy windows
    for (int t = 0; t < 6; t++) begin
      int lo;
      lo = $urandom_range(1, 10);
      run_xfer($urandom_range(0, 1023), $urandom_range(1, 12), 1, lo,
               lo + $urandom_range(0, 3), -1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
